// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and register-number constants for the MIPS datapath
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] REG_AT = 5'd1;
  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_GP = 5'd28;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_FP = 5'd30;
  localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/fivebitdecoder.sv
// fivebitdecoder: gate-level 5-to-32 one-hot decoder with enable (a_i select, en_i enable, y_o one-hot)
module fivebitdecoder (
  input  logic [4:0]  a_i,
  input  logic        en_i,
  output logic [31:0] y_o
);
  logic [4:0] an;
  for (genvar b = 0; b < 5; b++) begin : g_inv
    not u_not (an[b], a_i[b]);
  end
  for (genvar i = 0; i < 32; i++) begin : g_dec
    localparam logic [4:0] K = 5'(i);
    and u_and (y_o[i], en_i,
               K[4] ? a_i[4] : an[4],
               K[3] ? a_i[3] : an[3],
               K[2] ? a_i[2] : an[2],
               K[1] ? a_i[1] : an[1],
               K[0] ? a_i[0] : an[0]);
  end
endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two combinational read ports with write-through bypass, one sync write port, $zero hardwired
// ports: clk, rst (async active-high), raddr1/raddr2 -> rdata1/rdata2, we/waddr/wdata write port
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DW = mips_pkg::DATA_W,
  parameter int AW = mips_pkg::ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  localparam int N = 2 ** AW;
  logic [N-1:0]  dec, ld;
  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] regs_d [N];
  logic          byp1, byp2;
  fivebitdecoder u_dec (.a_i(waddr), .en_i(we), .y_o(dec));
  // entry 0 never loads, so reset keeps $zero at 0 forever
  always_comb begin
    ld = dec;
    ld[0] = 1'b0;
    for (int k = 0; k < N; k++) regs_d[k] = ld[k] ? wdata : regs_q[k];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < N; k++) regs_q[k] <= '0;
    else for (int k = 0; k < N; k++) regs_q[k] <= regs_d[k];
  always_comb begin
    byp1 = we && waddr != ZERO_REG && raddr1 == waddr;
    byp2 = we && waddr != ZERO_REG && raddr2 == waddr;
    rdata1 = (rst || raddr1 == ZERO_REG) ? '0 : byp1 ? wdata : regs_q[raddr1];
    rdata2 = (rst || raddr2 == ZERO_REG) ? '0 : byp2 ? wdata : regs_q[raddr2];
  end
endmodule
